// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and encodings for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: picks the E-stage operand source for rs_i (in: rs_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i; out: fwd_o = 10 M, 01 W, 00 regfile)
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);
  logic hit_m, hit_w;
  always_comb begin
    hit_m = reg_write_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i;
    hit_w = reg_write_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i;
    fwd_o = hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard control (in: D/E/M/W reg ids, load/branch/memory handshake; out: stage stalls/flushes, E forwarding selects, saturating stall/flush counters)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RESET_FLUSH_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            Rs1E,
  input  logic [4:0]            Rs2E,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic [4:0]            RdM,
  input  logic [4:0]            RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  DataMemReqM,
  input  logic                  DataMemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [DATA_WIDTH-1:0] StallCount,
  output logic [DATA_WIDTH-1:0] FlushCount
);
  localparam int CW = $clog2(RESET_FLUSH_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic in_init, mem_stall, lw_hit, br, lw;
  forward_sel u_fwd_a (
    .rs_i(Rs1E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(ForwardAE)
  );
  forward_sel u_fwd_b (
    .rs_i(Rs2E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(ForwardBE)
  );
  always_comb begin
    in_init = state_q == INIT;
    mem_stall = (state_q == RUN && DataMemReqM && !DataMemReadyM) ||
                (state_q == MEM_WAIT && !DataMemReadyM);
    lw_hit = ResultSrcE == RESULT_SRC_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    br = !in_init && !mem_stall && PCSrcE;
    lw = !in_init && !mem_stall && !PCSrcE && lw_hit;
    StallF = in_init || mem_stall || lw;
    StallD = mem_stall || lw;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushD = in_init || br;
    FlushE = in_init || br || lw;
    FlushW = in_init || mem_stall;
    state_d = in_init ? (cnt_q == CW'(1) ? RUN : INIT) : (mem_stall ? MEM_WAIT : RUN);
    cnt_d = (in_init && cnt_q != CW'(1)) ? cnt_q - CW'(1) : cnt_q;
    stall_cnt_d = (!in_init && StallF && !(&stall_cnt_q)) ? stall_cnt_q + DATA_WIDTH'(1) : stall_cnt_q;
    flush_cnt_d = (br && !(&flush_cnt_q)) ? flush_cnt_q + DATA_WIDTH'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= CW'(RESET_FLUSH_CYCLES);
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a rule-level model
module tb_hazard_ctrl;
  localparam int W = 6;
  localparam int RF = 3;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, DataMemReqM, DataMemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [W-1:0] StallCount, FlushCount;
  int total = 0;
  int bad = 0;
  int init_left, scnt, fcnt;
  bit waiting;
  hazard_ctrl #(.DATA_WIDTH(W), .RESET_FLUSH_CYCLES(RF)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .DataMemReqM(DataMemReqM),
    .DataMemReadyM(DataMemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount), .FlushCount(FlushCount)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, RegWriteW, DataMemReqM, DataMemReadyM} = '0;
  endtask
  task automatic model_reset();
    init_left = RF;
    waiting = 1'b0;
    scnt = 0;
    fcnt = 0;
  endtask
  task automatic step();
    logic mem, l;
    logic [6:0] e;
    mem = 1'b0;
    #1;
    if (init_left > 0) e = 7'b1000111;
    else begin
      mem = waiting ? !DataMemReadyM : (DataMemReqM && !DataMemReadyM);
      l = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      e = mem ? 7'b1111001 : PCSrcE ? 7'b0000110 : l ? 7'b1100010 : 7'b0;
    end
    chk("ctrl", {25'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'b0, e});
    chk("fwd", {28'b0, ForwardAE, ForwardBE}, {28'b0, fwd(Rs1E), fwd(Rs2E)});
    chk("stall_cnt", 32'(StallCount), 32'(scnt));
    chk("flush_cnt", 32'(FlushCount), 32'(fcnt));
    if (init_left > 0) init_left--;
    else begin
      waiting = mem;
      if (e[6] && scnt < MAXC) scnt++;
      if (!mem && PCSrcE && fcnt < MAXC) fcnt++;
    end
    @(negedge clk);
  endtask
  initial begin
    clr();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_ctrl", {25'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'b1000111);
    chk("rst_cnt", {StallCount, FlushCount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    step();
    RdE = 5'd0;
    step();
    clr();
    step();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7;
    step();
    RegWriteM = 1'b0;
    step();
    RegWriteM = 1'b1; RdM = 5'd0; Rs2E = 5'd0;
    step();
    clr();
    PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3;
    step();
    clr();
    step();
    DataMemReqM = 1'b1; PCSrcE = 1'b1;
    repeat (4) step();
    DataMemReadyM = 1'b1;
    step();
    clr();
    step();
    DataMemReqM = 1'b1;
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ctrl", {25'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'b1000111);
    chk("mid_rst_cnt", {StallCount, FlushCount}, 32'd0);
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 1500; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      DataMemReqM = ($urandom_range(0, 2) == 0);
      DataMemReadyM = 1'($urandom);
      step();
    end
    clr();
    DataMemReadyM = 1'b1;
    step();
    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
    repeat (70) step();
    clr();
    step();
    chk("stall_sat", 32'(StallCount), 32'(MAXC));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core: drives stall/flush/enable controls of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. Resolves load-use, taken-branch/jump and data-memory wait hazards with fixed priority, holds the pipeline in a flush sequence after reset, and keeps saturating stall/flush performance counters.

## Interface
- DATA_WIDTH, 32, width of performance counters.
- RESET_FLUSH_CYCLES, 3, cycles of forced flush after reset release (≥1).
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- Rs1D, Rs2D  in  5 each  source regs of instruction in D.
- Rs1E, Rs2E, RdE  in  5 each  source/dest regs of instruction in E.
- ResultSrcE  in  2  E-stage result select; 2'b01 = load.
- PCSrcE  in  1  branch taken or jump in E.
- RdM, RdW  in  5 each  dest regs in M, W.
- RegWriteM, RegWriteW  in  1 each  write enables in M, W.
- DataMemReqM  in  1  M-stage data memory access valid.
- DataMemReadyM  in  1  data memory completes this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE, FlushW  out  1 each  load bubble into D/E/W register.
- ForwardAE, ForwardBE  out  2 each  00 regfile, 01 from W, 10 from M.
- StallCount, FlushCount  out  DATA_WIDTH each  saturating counters.

## Operation
- FSM states: INIT, RUN, MEM_WAIT.
- INIT: StallF=1, FlushD=FlushE=FlushW=1, all other stall/flush 0. Down-counter loaded with RESET_FLUSH_CYCLES on reset; decrements each cycle; INIT→RUN when counter reaches 1 (exactly RESET_FLUSH_CYCLES INIT cycles).
- memStall = (RUN & DataMemReqM & ~DataMemReadyM) | (MEM_WAIT & ~DataMemReadyM).
- RUN→MEM_WAIT when DataMemReqM & ~DataMemReadyM; MEM_WAIT→RUN when DataMemReadyM (no stall that cycle).
- lwStall = ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Priority in RUN/MEM_WAIT: memStall > PCSrcE > lwStall.
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (branch in E held, re-evaluated on release).
  - PCSrcE: FlushD=FlushE=1, no stalls (squashes any load-use victim in D).
  - lwStall: StallF=StallD=1, FlushE=1.
  - none: all 0.
- Forwarding (all states, combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE same with Rs2E. M beats W on same reg; x0 never forwarded.
- StallCount: +1 each cycle StallF=1 outside INIT. FlushCount: +1 each cycle PCSrcE flush taken. Both saturate at all-ones, never wrap.

## Timing
- Stall/flush/forward outputs combinational from current state and inputs (same-cycle effect on pipeline registers at next edge).
- FSM, INIT counter, perf counters update on posedge clk.
- Reset (async, any state incl. mid-MEM_WAIT): state=INIT, counter=RESET_FLUSH_CYCLES, StallCount=FlushCount=0; outputs immediately at INIT values.
- DataMemReadyM while DataMemReqM=0 ignored in RUN.
- Inputs in INIT ignored except forwarding.

## Structure
- Package hazard_pkg: state enum (INIT, RUN, MEM_WAIT), forward constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, RESULT_SRC_LOAD=2'b01.
- Sub-module forward_sel (combinational, one source reg → 2-bit select), instantiated for A and B.

## Test plan
- Reset, RESET_FLUSH_CYCLES=3: StallF/FlushD/FlushE/FlushW high exactly 3 cycles after rst_n rises, then all 0; counters 0.
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 one cycle; RdE=0 → no stall; StallCount=1.
- Forwarding: RdM=RdW=7, both RegWrite, Rs1E=7 → ForwardAE=10; RegWriteM=0 → 01; Rs2E=0 with RdM=0 → ForwardBE=00.
- Branch vs load-use same cycle: PCSrcE=1 and lwStall → FlushD=FlushE=1, StallF=0; FlushCount +1.
- Memory wait: DataMemReqM=1, Ready low 4 cycles with PCSrcE=1 → all stalls+FlushW 4 cycles, FlushD/E=0; Ready cycle → branch flush, state RUN.
- rst_n low mid-MEM_WAIT → immediate INIT outputs, counters cleared; counter saturation: preload near max, extra stalls hold at all-ones.
